// File: rtl/sha256_block_feeder.sv
// SHA-256 message padder/blocker driving an external compression core and chaining its digest.
// Define SHA256_FEEDER_SHA224_EN for the SHA-224 IV and a truncated 224-bit digest_out.
module sha256_block_feeder #(
    parameter int unsigned LEN_W          = 64,
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         empty_in,
    input  logic         byte_valid_in,
    input  logic [7:0]   byte_in,
    input  logic         byte_last_in,
    output logic         byte_ready_out,
    output logic         blk_start_out,
    output logic [511:0] blk_message_out,
    output logic [255:0] blk_digest_out,
    input  logic [255:0] blk_digest_in,
    input  logic         blk_valid_in,
    output logic [255:0] digest_out,
    output logic         done_out,
    output logic         err_out
);

`ifdef SHA256_FEEDER_SHA224_EN
    localparam logic [255:0] IV = 256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4;
`else
    localparam logic [255:0] IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
`endif

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FILL, S_PAD, S_ISSUE, S_WAIT, S_PAD2, S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [511:0]   msg_q, msg_d;
    logic [255:0]   hblk_q, hblk_d;
    logic [255:0]   digest_q, digest_d;
    logic [6:0]     idx_q, idx_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [TW-1:0]  tcnt_q, tcnt_d;
    logic           final_q, final_d;
    logic           pad2_q, pad2_d;
    logic           done_q, done_d;
    logic           err_q, err_d;
    logic           xfer;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= S_IDLE;
            msg_q    <= '0;
            hblk_q   <= IV;
            digest_q <= '0;
            idx_q    <= '0;
            len_q    <= '0;
            tcnt_q   <= '0;
            final_q  <= 1'b0;
            pad2_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            msg_q    <= msg_d;
            hblk_q   <= hblk_d;
            digest_q <= digest_d;
            idx_q    <= idx_d;
            len_q    <= len_d;
            tcnt_q   <= tcnt_d;
            final_q  <= final_d;
            pad2_q   <= pad2_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        msg_d    = msg_q;
        hblk_d   = hblk_q;
        digest_d = digest_q;
        idx_d    = idx_q;
        len_d    = len_q;
        tcnt_d   = tcnt_q;
        final_d  = final_q;
        pad2_d   = pad2_q;
        done_d   = 1'b0;
        err_d    = err_q;

        byte_ready_out = (state_q == S_IDLE) || ((state_q == S_FILL) && !idx_q[6]);
        xfer           = byte_valid_in && byte_ready_out;

        unique case (state_q)
            S_IDLE: begin
                // A byte wins over empty_in when both arrive together.
                if (xfer) begin
                    msg_d           = '0;
                    msg_d[511:504]  = byte_in;
                    idx_d           = 7'd1;
                    len_d           = LEN_W'(8);
                    err_d           = 1'b0;
                    final_d         = 1'b0;
                    pad2_d          = 1'b0;
                    state_d         = byte_last_in ? S_PAD : S_FILL;
                end else if (empty_in) begin
                    msg_d   = '0;
                    idx_d   = '0;
                    len_d   = '0;
                    err_d   = 1'b0;
                    final_d = 1'b0;
                    pad2_d  = 1'b0;
                    state_d = S_PAD;
                end
            end
            S_FILL: begin
                if (xfer) begin
                    for (int unsigned k = 0; k < 64; k++) begin
                        if (7'(k) == idx_q) msg_d[511-8*k -: 8] = byte_in;
                    end
                    idx_d = idx_q + 7'd1;
                    len_d = len_q + LEN_W'(8);
                    if (byte_last_in)          state_d = S_PAD;
                    else if (idx_q == 7'd63)   state_d = S_ISSUE;
                end
            end
            S_PAD: begin
                // A full 64-byte block is issued as-is; its 0x80 marker moves to the extra block.
                if (idx_q[6]) begin
                    pad2_d  = 1'b1;
                    final_d = 1'b0;
                end else begin
                    for (int unsigned k = 0; k < 64; k++) begin
                        if (7'(k) == idx_q)     msg_d[511-8*k -: 8] = 8'h80;
                        else if (7'(k) > idx_q) msg_d[511-8*k -: 8] = 8'h00;
                    end
                    if (idx_q <= 7'd55) begin
                        msg_d[63:0] = 64'(len_q);
                        final_d     = 1'b1;
                        pad2_d      = 1'b0;
                    end else begin
                        final_d = 1'b0;
                        pad2_d  = 1'b1;
                    end
                end
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                tcnt_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (blk_valid_in) begin
                    hblk_d = blk_digest_in;
                    if (final_q) begin
                        state_d = S_DONE;
                    end else if (pad2_q) begin
                        state_d = S_PAD2;
                    end else begin
                        idx_d   = '0;
                        state_d = S_FILL;
                    end
                end else if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    hblk_d  = IV;
                    state_d = S_IDLE;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            S_PAD2: begin
                msg_d = '0;
                if (idx_q[6]) msg_d[511:504] = 8'h80;
                msg_d[63:0] = 64'(len_q);
                final_d     = 1'b1;
                pad2_d      = 1'b0;
                state_d     = S_ISSUE;
            end
            S_DONE: begin
`ifdef SHA256_FEEDER_SHA224_EN
                digest_d = {hblk_q[255:32], 32'h0};
`else
                digest_d = hblk_q;
`endif
                done_d  = 1'b1;
                hblk_d  = IV;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign blk_start_out   = (state_q == S_ISSUE);
    assign blk_message_out = msg_q;
    assign blk_digest_out  = hblk_q;
    assign digest_out      = digest_q;
    assign done_out        = done_q;
    assign err_out         = err_q;

endmodule

// File: tb/tb_sha256_block_feeder.sv
// Directed bench for sha256_block_feeder with a behavioural SHA-256 compression core on the blk_* ports.
module tb_sha256_block_feeder;

    localparam int unsigned TO = 40;

`ifdef SHA256_FEEDER_SHA224_EN
    localparam logic [255:0] IV      = 256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4;
    localparam logic [255:0] D_ABC   = 256'h23097d22_3405d822_8642a477_bda255b3_2aadbce4_bda0b3f7_e36c9da7_00000000;
    localparam logic [255:0] D_EMPTY = 256'hd14a028c_2a3a2bc9_476102bb_288234c4_15a2b01f_828ea62a_c5b3e42f_00000000;
    localparam logic [255:0] D_448   = 256'h75388b16_512776cc_5dba5da1_fd890150_b0c6455c_b4f58b19_52522525_00000000;
`else
    localparam logic [255:0] IV      = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [255:0] D_ABC   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] D_EMPTY = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
    localparam logic [255:0] D_448   = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
`endif

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic         CLK = 1'b0;
    logic         RST;
    logic         empty_in, byte_valid_in, byte_last_in;
    logic [7:0]   byte_in;
    logic         byte_ready_out, blk_start_out, blk_valid_in, done_out, err_out;
    logic [511:0] blk_message_out;
    logic [255:0] blk_digest_out, blk_digest_in, digest_out;

    sha256_block_feeder #(.LEN_W(64), .TIMEOUT_CYCLES(TO)) dut (
        .CLK(CLK), .RST(RST), .empty_in(empty_in), .byte_valid_in(byte_valid_in),
        .byte_in(byte_in), .byte_last_in(byte_last_in), .byte_ready_out(byte_ready_out),
        .blk_start_out(blk_start_out), .blk_message_out(blk_message_out),
        .blk_digest_out(blk_digest_out), .blk_digest_in(blk_digest_in),
        .blk_valid_in(blk_valid_in), .digest_out(digest_out), .done_out(done_out),
        .err_out(err_out)
    );

    always #5 CLK = ~CLK;

    int nvec = 0;
    int nerr = 0;
    int issues = 0;
    int done_cnt = 0;
    bit core_on = 1'b1;
    logic [511:0] last_msg = '0;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] m);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
        for (int i = 0; i < 16; i++) w[i] = m[511-32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = s1 + w[i-7] + s0 + w[i-16];
        end
        {a, b, c, d, e, f, g, h} = hin;
        for (int i = 0; i < 64; i++) begin
            t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
            t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        return {a + hin[255:224], b + hin[223:192], c + hin[191:160], d + hin[159:128],
                e + hin[127:96],  f + hin[95:64],   g + hin[63:32],   h + hin[31:0]};
    endfunction

    function automatic logic [7:0] msg_byte(input int sel, input int i);
        int c;
        case (sel)
            0:       c = 97 + i;
            1:       c = 97 + i / 4 + i % 4;
            default: c = 97;
        endcase
        return c[7:0];
    endfunction

    function automatic logic [31:0] word_of(input logic [511:0] blk, input int k);
        logic [511:0] t;
        t = blk >> (480 - 32 * k);
        return t[31:0];
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Behavioural core: result two cycles after start, valid held for two cycles.
    initial begin
        logic [255:0] hres;
        blk_valid_in  = 1'b0;
        blk_digest_in = '0;
        forever begin
            @(negedge CLK);
            while (blk_start_out && !RST) begin
                issues++;
                last_msg = blk_message_out;
                if (!core_on) break;
                hres = compress(blk_digest_out, blk_message_out);
                repeat (2) @(negedge CLK);
                blk_digest_in = hres;
                blk_valid_in  = 1'b1;
                repeat (2) @(negedge CLK);
                blk_valid_in  = 1'b0;
            end
        end
    end

    always @(negedge CLK) if (done_out) done_cnt++;

    task automatic send_msg(input int sel, input int len, input bit empty, input bit with_empty);
        int t;
        if (empty) begin
            empty_in = 1'b1;
            @(negedge CLK);
            empty_in = 1'b0;
        end else begin
            for (int i = 0; i < len; i++) begin
                byte_valid_in = 1'b1;
                byte_in       = msg_byte(sel, i);
                byte_last_in  = (i == len - 1);
                empty_in      = with_empty && (i == 0);
                t = 0;
                while (!byte_ready_out && t < 200) begin
                    @(negedge CLK);
                    t++;
                end
                if (t >= 200) begin
                    check("byte_accept_timeout", 256'(t), 256'(0));
                    break;
                end
                @(negedge CLK);
            end
            byte_valid_in = 1'b0;
            byte_last_in  = 1'b0;
            empty_in      = 1'b0;
        end
    endtask

    task automatic wait_done(output bit seen, output logic [255:0] d);
        seen = 1'b0;
        d    = '0;
        for (int t = 0; t < 400; t++) begin
            if (done_out) begin
                seen = 1'b1;
                d    = digest_out;
                break;
            end
            @(negedge CLK);
        end
    endtask

    typedef struct {
        int          sel;
        int          len;
        bit          empty;
        int          exp_issues;
        logic [31:0] w0;
        int          k;
        logic [31:0] wk;
        logic [31:0] w15;
        bit          chk_dig;
        logic [255:0] dig;
    } vec_t;

    vec_t vecs [7];

    initial begin
        bit seen;
        logic [255:0] d;
        int t;

        vecs[0] = '{0, 3,  1'b0, 1, 32'h61626380, 13, 32'h00000000, 32'h00000018, 1'b1, D_ABC};
        vecs[1] = '{0, 0,  1'b1, 1, 32'h80000000, 13, 32'h00000000, 32'h00000000, 1'b1, D_EMPTY};
        vecs[2] = '{1, 56, 1'b0, 2, 32'h00000000, 13, 32'h00000000, 32'h000001c0, 1'b1, D_448};
        vecs[3] = '{2, 55, 1'b0, 1, 32'h61616161, 13, 32'h61616180, 32'h000001b8, 1'b0, '0};
        vecs[4] = '{2, 64, 1'b0, 2, 32'h80000000, 13, 32'h00000000, 32'h00000200, 1'b0, '0};
        vecs[5] = '{2, 60, 1'b0, 2, 32'h00000000, 13, 32'h00000000, 32'h000001e0, 1'b0, '0};
        vecs[6] = '{2, 70, 1'b0, 2, 32'h61616161, 1,  32'h61618000, 32'h00000230, 1'b0, '0};

        RST = 1'b1; empty_in = 1'b0; byte_valid_in = 1'b0; byte_last_in = 1'b0; byte_in = '0;
        #12;
        check("rst_ready",   256'(byte_ready_out), 256'(1));
        check("rst_start",   256'(blk_start_out), 256'(0));
        check("rst_done",    256'(done_out), 256'(0));
        check("rst_err",     256'(err_out), 256'(0));
        check("rst_digest",  digest_out, '0);
        check("rst_blkmsg",  blk_message_out[255:0] | blk_message_out[511:256], '0);
        check("rst_blkdig",  blk_digest_out, IV);
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);

        for (int v = 0; v < 7; v++) begin
            issues = 0;
            send_msg(vecs[v].sel, vecs[v].len, vecs[v].empty, 1'b0);
            wait_done(seen, d);
            check($sformatf("v%0d_done", v), 256'(seen), 256'(1));
            check($sformatf("v%0d_issues", v), 256'(issues), 256'(vecs[v].exp_issues));
            check($sformatf("v%0d_w0", v), 256'(word_of(last_msg, 0)), 256'(vecs[v].w0));
            check($sformatf("v%0d_w%0d", v, vecs[v].k), 256'(word_of(last_msg, vecs[v].k)), 256'(vecs[v].wk));
            check($sformatf("v%0d_w15", v), 256'(word_of(last_msg, 15)), 256'(vecs[v].w15));
            if (vecs[v].chk_dig) check($sformatf("v%0d_digest", v), d, vecs[v].dig);
            @(negedge CLK);
            check($sformatf("v%0d_blkdig_iv", v), blk_digest_out, IV);
        end

        // Byte and empty_in together in IDLE: the byte stream wins.
        issues = 0;
        send_msg(0, 3, 1'b0, 1'b1);
        wait_done(seen, d);
        check("prec_done", 256'(seen), 256'(1));
        check("prec_digest", d, D_ABC);
        check("prec_issues", 256'(issues), 256'(1));
        @(negedge CLK);

        // Core never answers: err after TO WAIT cycles, no done, chaining reset.
        core_on  = 1'b0;
        done_cnt = 0;
        send_msg(0, 3, 1'b0, 1'b0);
        t = 0;
        while (!blk_start_out && t < 50) begin
            @(negedge CLK);
            t++;
        end
        check("to_start_seen", 256'(blk_start_out), 256'(1));
        @(posedge CLK);
        repeat (TO - 1) @(posedge CLK);
        #1;
        check("to_err_early", 256'(err_out), 256'(0));
        @(posedge CLK);
        #1;
        check("to_err", 256'(err_out), 256'(1));
        check("to_ready", 256'(byte_ready_out), 256'(1));
        check("to_blkdig_iv", blk_digest_out, IV);
        repeat (3) @(negedge CLK);
        check("to_err_sticky", 256'(err_out), 256'(1));
        check("to_no_done", 256'(done_cnt), 256'(0));

        // err cleared by empty_in; message still hashes correctly.
        core_on = 1'b1;
        send_msg(0, 0, 1'b1, 1'b0);
        check("errclr", 256'(err_out), 256'(0));
        wait_done(seen, d);
        check("errclr_digest", d, D_EMPTY);
        @(negedge CLK);

        // Asynchronous reset in the middle of WAIT.
        core_on = 1'b0;
        send_msg(0, 3, 1'b0, 1'b0);
        repeat (3) @(negedge CLK);
        #2;
        RST = 1'b1;
        #1;
        check("arst_ready",  256'(byte_ready_out), 256'(1));
        check("arst_start",  256'(blk_start_out), 256'(0));
        check("arst_err",    256'(err_out), 256'(0));
        check("arst_digest", digest_out, '0);
        check("arst_blkmsg", blk_message_out[255:0] | blk_message_out[511:256], '0);
        check("arst_blkdig", blk_digest_out, IV);
        @(negedge CLK);
        RST = 1'b0;
        core_on = 1'b1;
        @(negedge CLK);
        send_msg(0, 3, 1'b0, 1'b0);
        wait_done(seen, d);
        check("post_rst_digest", d, D_ABC);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
